hazard_scoreboard: RTL and testbench

Consumer-side hazard controller for the five-stage MIPS pipeline: tracks destination register and remaining result latency (Tnew) of instructions in E/M/W, and issues stall and forwarding-source selects to the D-stage and E-stage operand muxes. Owns the multiply/divide busy counter, so one block decides every D-stage stall. Sits beside the pipeline registers; the datapath consumes its selects directly.

---
 rtl/hazard_scoreboard_pkg.sv | 50 +++++
 rtl/hazard_scoreboard_if.sv | 32 +++
 rtl/hazard_match.sv | 20 ++
 rtl/hazard_scoreboard.sv | 128 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the D-stage hazard scoreboard: Tnew/Tuse codes,
// forwarding-select codes, multiply/divide start codes and stage records.
package hazard_scoreboard_pkg;

   // Tnew: cycles from E entry until the result can be forwarded
   localparam logic [1:0] TNEW_JAL  = 2'd0;
   localparam logic [1:0] TNEW_ALU  = 2'd1;
   localparam logic [1:0] TNEW_LOAD = 2'd2;

   // Tuse: stage in which the D instruction first needs the operand
   localparam logic [1:0] TUSE_D    = 2'd0;
   localparam logic [1:0] TUSE_E    = 2'd1;
   localparam logic [1:0] TUSE_M    = 2'd2;
   localparam logic [1:0] TUSE_NONE = 2'd3;

   // Operand-mux source selects
   localparam logic [1:0] FWD_GRF = 2'd0;
   localparam logic [1:0] FWD_E   = 2'd1;
   localparam logic [1:0] FWD_M   = 2'd2;
   localparam logic [1:0] FWD_W   = 2'd3;

   // Multiply/divide start codes
   localparam logic [1:0] MD_NONE = 2'b00;
   localparam logic [1:0] MD_MULT = 2'b01;
   localparam logic [1:0] MD_DIV  = 2'b10;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // E entry keeps sources for E-side forwarding and the md-start type
   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dst;
      logic [1:0] tnew;
      logic [1:0] md;
   } e_stage_t;

   // M/W entries only ever act as producers
   typedef struct packed {
      logic [4:0] dst;
      logic [1:0] tnew;
   } mw_stage_t;

   // Remaining latency one stage later, saturating at zero
   function automatic logic [1:0] tnew_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage request / hazard-control response bundle between the pipeline
// (master) and the scoreboard (slave).
interface hazard_scoreboard_if;
   import hazard_scoreboard_pkg::*;

   logic [4:0] D_rs;
   logic [4:0] D_rt;
   logic [1:0] D_tuse_rs;
   logic [1:0] D_tuse_rt;
   logic [4:0] D_dst;
   logic [1:0] D_tnew;
   logic [1:0] D_md_start;
   logic       D_md_use;

   logic       stall;
   logic [1:0] D_fwd_rs;
   logic [1:0] D_fwd_rt;
   logic [1:0] E_fwd_rs;
   logic [1:0] E_fwd_rt;
   logic       md_busy;

   modport master (
      output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_dst, D_tnew, D_md_start, D_md_use,
      input  stall, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, md_busy
   );

   modport slave (
      input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_dst, D_tnew, D_md_start, D_md_use,
      output stall, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, md_busy
   );

endinterface

// File: rtl/hazard_match.sv
// One consumer-source vs one producer-stage comparison. Register 0 never
// matches; a match is forwardable once the producer's Tnew reaches zero and
// must stall while the producer is later than the consumer's Tuse.
module hazard_match
   import hazard_scoreboard_pkg::*;
(
   input  logic [4:0] src_i,
   input  logic [4:0] dst_i,
   input  logic [1:0] tnew_i,
   input  logic [1:0] tuse_i,
   output logic       match_o,
   output logic       ready_o,
   output logic       stall_o
);

   assign match_o = (src_i != '0) && (src_i == dst_i);
   assign ready_o = match_o && (tnew_i == '0);
   assign stall_o = match_o && (tuse_i != TUSE_NONE) && (tnew_i > tuse_i);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks dst/Tnew of the E/M/W instructions, owns the
// multiply/divide busy counter, and produces the D-stage stall plus the
// D-side and E-side forwarding selects.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input  logic                clk,
   input  logic                reset_n,
   hazard_scoreboard_if.slave  hs
);

   localparam int NSTG = 3;   // producer stage index: 0 = E, 1 = M, 2 = W

   e_stage_t   e_q, e_d;
   mw_stage_t  m_q, m_d, w_q, w_d;
   logic [3:0] md_cnt_q, md_cnt_d;

   logic [NSTG-1:0][4:0] stg_dst;
   logic [NSTG-1:0][1:0] stg_tnew;

   // consumer source index: 0 = rs, 1 = rt
   logic [1:0][4:0]      d_src, e_src;
   logic [1:0][1:0]      d_tuse;
   logic [1:0][NSTG-1:0] d_match, d_ready, d_stall;
   logic [1:0][1:0]      e_match, e_ready, e_stall_unused;   // [src][stage-1]
   logic [1:0][1:0]      d_fwd, e_fwd;

   logic e_md_start, md_stall, stall;

   assign stg_dst  = {w_q.dst,  m_q.dst,  e_q.dst};
   assign stg_tnew = {w_q.tnew, m_q.tnew, e_q.tnew};
   assign d_src    = {hs.D_rt, hs.D_rs};
   assign d_tuse   = {hs.D_tuse_rt, hs.D_tuse_rs};
   assign e_src    = {e_q.rt, e_q.rs};

   for (genvar s = 0; s < 2; s++) begin : g_src
      for (genvar g = 0; g < NSTG; g++) begin : g_d
         hazard_match u_d (
            .src_i   (d_src[s]),
            .dst_i   (stg_dst[g]),
            .tnew_i  (stg_tnew[g]),
            .tuse_i  (d_tuse[s]),
            .match_o (d_match[s][g]),
            .ready_o (d_ready[s][g]),
            .stall_o (d_stall[s][g])
         );
      end
      // E operands are already committed to issue, so they never stall
      for (genvar g = 1; g < NSTG; g++) begin : g_e
         hazard_match u_e (
            .src_i   (e_src[s]),
            .dst_i   (stg_dst[g]),
            .tnew_i  (stg_tnew[g]),
            .tuse_i  (TUSE_NONE),
            .match_o (e_match[s][g-1]),
            .ready_o (e_ready[s][g-1]),
            .stall_o (e_stall_unused[s][g-1])
         );
      end
   end

   assign e_md_start = (e_q.md == MD_MULT) || (e_q.md == MD_DIV);
   assign md_stall   = hs.D_md_use && ((md_cnt_q != '0) || e_md_start);
   assign stall      = (|d_stall) || md_stall;

   // Youngest matching producer wins; a not-yet-ready match reads GRF under stall
   always_comb begin
      d_fwd = '0;
      e_fwd = '0;
      for (int s = 0; s < 2; s++) begin
         if (d_match[s][0])      d_fwd[s] = d_ready[s][0] ? FWD_E : FWD_GRF;
         else if (d_match[s][1]) d_fwd[s] = d_ready[s][1] ? FWD_M : FWD_GRF;
         else if (d_match[s][2]) d_fwd[s] = d_ready[s][2] ? FWD_W : FWD_GRF;
         if (e_match[s][0])      e_fwd[s] = e_ready[s][0] ? FWD_M : FWD_GRF;
         else if (e_match[s][1]) e_fwd[s] = e_ready[s][1] ? FWD_W : FWD_GRF;
      end
   end

   // Stage advance: D enters E unless stalled (bubble), Tnew ages each stage
   always_comb begin
      e_d = '0;
      if (!stall) begin
         e_d.rs   = hs.D_rs;
         e_d.rt   = hs.D_rt;
         e_d.dst  = hs.D_dst;
         e_d.tnew = hs.D_tnew;
         e_d.md   = hs.D_md_start;
      end
      m_d.dst  = e_q.dst;
      m_d.tnew = tnew_dec(e_q.tnew);
      w_d.dst  = m_q.dst;
      w_d.tnew = tnew_dec(m_q.tnew);
   end

   // Busy counter: reloads when an md op sits in E, otherwise drains to zero
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (e_q.md == MD_MULT)     md_cnt_d = 4'(MULT_CYCLES);
      else if (e_q.md == MD_DIV) md_cnt_d = 4'(DIV_CYCLES);
      else if (md_cnt_q != '0)   md_cnt_d = md_cnt_q - 4'd1;
   end

   // Pipeline-shadow state; reset empties every stage and the counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e_q      <= '0;
         m_q      <= '0;
         w_q      <= '0;
         md_cnt_q <= '0;
      end else begin
         e_q      <= e_d;
         m_q      <= m_d;
         w_q      <= w_d;
         md_cnt_q <= md_cnt_d;
      end
   end

   assign hs.stall    = stall;
   assign hs.D_fwd_rs = d_fwd[0];
   assign hs.D_fwd_rt = d_fwd[1];
   assign hs.E_fwd_rs = e_fwd[0];
   assign hs.E_fwd_rt = e_fwd[1];
   assign hs.md_busy  = (md_cnt_q != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus random
// instruction streams, checked each cycle against an in-flight-list model.
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic clk = 1'b0;
   logic reset_n;

   hazard_scoreboard_if hif ();

   hazard_scoreboard #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .hs      (hif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs, rt, dst;
      int tuse_rs, tuse_rt, tnew, md;
      bit md_use;
   } ins_t;

   // in-flight instruction, indexed by age since E entry (0 = E, 1 = M, 2 = W)
   typedef struct {
      logic [4:0] rs, rt, dst;
      int tnew, md;
   } ent_t;

   ent_t pipe [3];
   int   cyc, md_lo, md_hi;
   int   n_chk, n_pass, busy_seen;
   int   last_drs, last_drt;
   int   nst;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic ins_t mk(input int rs, input int trs, input int rt, input int trt,
                               input int dst, input int tnew, input int md, input bit mu);
      ins_t d;
      d.rs = 5'(rs); d.tuse_rs = trs; d.rt = 5'(rt); d.tuse_rt = trt;
      d.dst = 5'(dst); d.tnew = tnew; d.md = md; d.md_use = mu;
      return d;
   endfunction

   function automatic ent_t bubble();
      ent_t e;
      e.rs = '0; e.rt = '0; e.dst = '0; e.tnew = 0; e.md = 0;
      return e;
   endfunction

   // result latency still outstanding at a given age
   function automatic int rem(input int t, input int age);
      return (t > age) ? t - age : 0;
   endfunction

   function automatic bit busy_exp();
      return (cyc >= md_lo) && (cyc <= md_hi);
   endfunction

   function automatic bit src_stall(input logic [4:0] src, input int tuse);
      for (int a = 0; a < 2; a++)
         if (tuse != 3 && src != '0 && src == pipe[a].dst && rem(pipe[a].tnew, a) > tuse)
            return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_stall(input ins_t d);
      if (src_stall(d.rs, d.tuse_rs) || src_stall(d.rt, d.tuse_rt)) return 1'b1;
      if (d.md_use && (busy_exp() || pipe[0].md != 0)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int d_sel(input logic [4:0] src);
      for (int a = 0; a < 3; a++)
         if (src != '0 && src == pipe[a].dst)
            return (rem(pipe[a].tnew, a) == 0) ? a + 1 : 0;
      return 0;
   endfunction

   function automatic int e_sel(input logic [4:0] src);
      for (int a = 1; a < 3; a++)
         if (src != '0 && src == pipe[a].dst)
            return (rem(pipe[a].tnew, a) == 0) ? a + 1 : 0;
      return 0;
   endfunction

   task automatic drive(input ins_t d);
      hif.D_rs       = d.rs;
      hif.D_rt       = d.rt;
      hif.D_tuse_rs  = 2'(d.tuse_rs);
      hif.D_tuse_rt  = 2'(d.tuse_rt);
      hif.D_dst      = d.dst;
      hif.D_tnew     = 2'(d.tnew);
      hif.D_md_start = 2'(d.md);
      hif.D_md_use   = d.md_use;
   endtask

   task automatic check_cycle(input ins_t d, output bit st);
      @(negedge clk);
      st = m_stall(d);
      chk("stall",    int'(hif.stall),    int'(st));
      chk("D_fwd_rs", int'(hif.D_fwd_rs), d_sel(d.rs));
      chk("D_fwd_rt", int'(hif.D_fwd_rt), d_sel(d.rt));
      chk("E_fwd_rs", int'(hif.E_fwd_rs), e_sel(pipe[0].rs));
      chk("E_fwd_rt", int'(hif.E_fwd_rt), e_sel(pipe[0].rt));
      chk("md_busy",  int'(hif.md_busy),  int'(busy_exp()));
      if (hif.md_busy) busy_seen++;
      last_drs = int'(hif.D_fwd_rs);
      last_drt = int'(hif.D_fwd_rt);
   endtask

   task automatic advance(input ins_t d, input bit st);
      @(posedge clk);
      if (pipe[0].md == 1)      begin md_lo = cyc + 1; md_hi = cyc + MC; end
      else if (pipe[0].md == 2) begin md_lo = cyc + 1; md_hi = cyc + DC; end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (st) pipe[0] = bubble();
      else begin
         pipe[0].rs = d.rs; pipe[0].rt = d.rt; pipe[0].dst = d.dst;
         pipe[0].tnew = d.tnew; pipe[0].md = d.md;
      end
      cyc++;
      #1;
   endtask

   // hold an instruction in D until it issues; returns the stall cycle count
   task automatic issue(input ins_t d, output int n);
      bit st;
      n = 0;
      busy_seen = 0;
      drive(d);
      for (int i = 0; i < 32; i++) begin
         check_cycle(d, st);
         advance(d, st);
         if (!st) break;
         n++;
      end
   endtask

   task automatic model_reset();
      for (int a = 0; a < 3; a++) pipe[a] = bubble();
      md_lo = 1;
      md_hi = 0;
   endtask

   ins_t nop, d;

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0; busy_seen = 0;
      model_reset();
      nop = mk(0, 3, 0, 3, 0, 0, 0, 1'b0);

      // reset state, with a hazard-looking D instruction present
      reset_n = 1'b0;
      drive(mk(1, 0, 2, 0, 3, 2, 1, 1'b1));
      #2;
      chk("rst_stall",    int'(hif.stall),    0);
      chk("rst_D_fwd_rs", int'(hif.D_fwd_rs), 0);
      chk("rst_D_fwd_rt", int'(hif.D_fwd_rt), 0);
      chk("rst_E_fwd_rs", int'(hif.E_fwd_rs), 0);
      chk("rst_E_fwd_rt", int'(hif.E_fwd_rt), 0);
      chk("rst_md_busy",  int'(hif.md_busy),  0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // load-use: lw $1 then addu $2,$1,$3
      issue(mk(29, 1, 0, 3, 1, 2, 0, 1'b0), nst);
      issue(mk(1, 1, 3, 1, 2, 1, 0, 1'b0), nst);
      chk("lw_addu_stalls", nst, 1);
      issue(nop, nst);
      issue(nop, nst);

      // jal then jr $31
      issue(mk(0, 3, 0, 3, 31, 0, 0, 1'b0), nst);
      issue(mk(31, 0, 0, 3, 0, 0, 0, 1'b0), nst);
      chk("jal_jr_stalls", nst, 0);
      chk("jal_jr_D_fwd_rs", last_drs, 1);

      // addu $4 then beq $4,$4
      issue(mk(5, 1, 6, 1, 4, 1, 0, 1'b0), nst);
      issue(mk(4, 0, 4, 0, 0, 0, 0, 1'b0), nst);
      chk("addu_beq_stalls", nst, 1);
      chk("addu_beq_D_fwd_rs", last_drs, 2);
      chk("addu_beq_D_fwd_rt", last_drt, 2);

      // writes to $0 then a reader of $0
      issue(mk(1, 1, 0, 3, 0, 2, 0, 1'b0), nst);
      issue(mk(1, 1, 0, 3, 0, 1, 0, 1'b0), nst);
      issue(mk(1, 1, 0, 3, 0, 1, 0, 1'b0), nst);
      issue(mk(0, 0, 0, 0, 0, 0, 0, 1'b0), nst);
      chk("r0_stalls", nst, 0);
      chk("r0_D_fwd_rs", last_drs, 0);
      chk("r0_D_fwd_rt", last_drt, 0);

      // mult then mflo, div then mfhi
      issue(mk(5, 1, 6, 1, 0, 0, 1, 1'b1), nst);
      chk("mult_issue_stalls", nst, 0);
      issue(mk(0, 3, 0, 3, 7, 1, 0, 1'b1), nst);
      chk("mflo_stalls", nst, 1 + MC);
      chk("mult_busy_cycles", busy_seen, MC);
      issue(mk(5, 1, 6, 1, 0, 0, 2, 1'b1), nst);
      chk("div_issue_stalls", nst, 0);
      issue(mk(0, 3, 0, 3, 8, 1, 0, 1'b1), nst);
      chk("mfhi_stalls", nst, 1 + DC);
      chk("div_busy_cycles", busy_seen, DC);

      // reset asserted in the middle of a load-use stall with md busy
      issue(mk(5, 1, 6, 1, 0, 0, 1, 1'b1), nst);
      issue(mk(29, 1, 0, 3, 1, 2, 0, 1'b0), nst);
      d = mk(1, 1, 3, 1, 2, 1, 0, 1'b0);
      drive(d);
      begin
         bit st;
         check_cycle(d, st);
      end
      chk("pre_reset_stall",   int'(hif.stall),   1);
      chk("pre_reset_md_busy", int'(hif.md_busy), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_stall",    int'(hif.stall),    0);
      chk("async_rst_D_fwd_rs", int'(hif.D_fwd_rs), 0);
      chk("async_rst_D_fwd_rt", int'(hif.D_fwd_rt), 0);
      chk("async_rst_E_fwd_rs", int'(hif.E_fwd_rs), 0);
      chk("async_rst_E_fwd_rt", int'(hif.E_fwd_rt), 0);
      chk("async_rst_md_busy",  int'(hif.md_busy),  0);
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b1;
      issue(mk(6, 1, 7, 1, 8, 1, 0, 1'b0), nst);
      chk("post_rst_stalls_a", nst, 0);
      issue(mk(10, 1, 11, 1, 12, 1, 0, 1'b0), nst);
      chk("post_rst_stalls_b", nst, 0);
      issue(mk(14, 1, 0, 3, 13, 2, 0, 1'b0), nst);
      chk("post_rst_stalls_c", nst, 0);

      // random streams over a small register set to provoke collisions
      for (int i = 0; i < 400; i++) begin
         int k;
         k = int'($urandom_range(0, 9));
         d = mk(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 0, 1'b0);
         if (k == 0) begin
            d.md = int'($urandom_range(1, 2));
            d.md_use = 1'b1;
            d.dst = '0;
         end else if (k == 1) begin
            d.md_use = 1'b1;
            d.tnew = 1;
         end
         issue(d, nst);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
